operand_mux_stage: RTL and testbench
====================================

# operand_mux_stage

Registered, parametrised N-way operand select stage for the pipelined MIPS datapath, generalising the 3-input 32-bit forwarding select into a flow-controlled pipeline stage. It picks one of N_IN words by a select code, registers the result behind a valid/ready handshake and optionally buffers one extra word so upstream never stalls on a single-cycle downstream stall. An illegal select code reproduces the previous legal selection and is flagged and counted. It sits between hazard/forwarding control and the EX-stage ALU operand inputs.

## Interface
- WIDTH, 32, data word width in bits
- N_IN, 3, number of selectable inputs (2..16)
- SEL_W, 2, select width; SEL_W >= clog2(N_IN)
- ERR_CNT_W, 8, width of illegal-select counter
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset; synchronous and active-high
- in_data  input  N_IN*WIDTH  flattened inputs, word i at bits [i*WIDTH +: WIDTH]
- in_sel  input  SEL_W  select code, sampled with in_data
- in_valid  input  1  upstream word/select valid
- in_ready  output  1  stage can accept this cycle
- out_data  output  WIDTH  registered selected word
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- sel_err  output  1  sticky: an illegal select was accepted
- err_clr  input  1  clears sel_err and err_cnt
- err_cnt  output  ERR_CNT_W  saturating count of accepted illegal selects

## Operation
- Accept: in_valid && in_ready. Drain: out_valid && out_ready.
- Selected word: in_data[in_sel] when in_sel < N_IN; otherwise last_word (register holding the most recent legally selected word, reset 0).
- last_word updates only on accepted legal selects.
- Illegal accepted select: sel_err <= 1, err_cnt += 1 saturating at all-ones. Illegal selects never drop the transfer; the held word is delivered.
- err_clr has priority over a same-cycle illegal accept: result sel_err=0, err_cnt=0.
- States (SKID build): EMPTY (no words), MAIN (out reg valid), SKID (out reg + skid reg valid).
  - EMPTY: accept -> MAIN.
  - MAIN: accept & drain -> MAIN (new word); accept & !drain -> SKID (new word to skid); drain & !accept -> EMPTY.
  - SKID: in_ready=0; drain -> MAIN, skid word moves to out reg.
- Ordering strictly FIFO; no word lost or duplicated.
- Reset: state EMPTY, out_valid=0, out_data=0, in_ready=1 after reset, sel_err=0, err_cnt=0, last_word=0. Reset mid-transfer discards buffered words.

## Timing
- Latency: accepted word visible on out_data the cycle after accept.
- Throughput: one word/cycle while out_ready=1.
- in_ready (SKID build) is a register output: high in EMPTY and MAIN, low in SKID.
- sel_err/err_cnt update the cycle after the illegal accept.
- During rst, in_ready=0; no accept.

## Configuration
- OPERAND_MUX_SKID_EN defined: three-state skid behaviour above; in_ready registered.
- Not defined: single output register only; in_ready = !out_valid || out_ready (combinational); states EMPTY/MAIN only; skid register absent.
- Data path, error logic and latency identical in both builds.

## Structure
- Shared package mips_pipe_pkg: state enum (EMPTY, MAIN, SKID), default WIDTH constant, ERR_CNT_W default.
- One sub-module: operand_word_sel (combinational N_IN-way select with legal flag); stage wraps it with registers and FSM.

## Test plan
- Legal selects, out_ready=1: N_IN=3, words 0x11,0x22,0x33, sel 0,1,2 -> out_data 0x11,0x22,0x33 on consecutive cycles, one cycle after each accept.
- Illegal select: sel=1 (0x22) then sel=3 -> second output 0x22, sel_err=1, err_cnt=1; then err_clr -> both 0.
- Backpressure (SKID build): out_ready=0 with two accepts -> state SKID, in_ready=0; release out_ready -> both words out in order, no loss.
- Non-SKID build same stimulus -> second word held off by in_ready=0 until first drains; in_ready follows out_ready same cycle.
- Counter saturation: ERR_CNT_W=2, five illegal accepts -> err_cnt=3.
- Reset mid-transfer in SKID state -> next cycle out_valid=0, out_data=0, err_cnt=0; after rst low, in_ready=1.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: stage state encoding and default widths.
package mips_pipe_pkg;

  localparam int unsigned WIDTH_DEF     = 32;
  localparam int unsigned ERR_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/operand_word_sel.sv
// Combinational N_IN-way word select; an out-of-range code falls back to last_word.
module operand_word_sel #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_IN  = 3,
  parameter int unsigned SEL_W = 2
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic [WIDTH-1:0]      last_word,
  output logic [WIDTH-1:0]      word_c,
  output logic                  legal_c
);

  always_comb begin
    legal_c = 1'b0;
    word_c  = last_word;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (sel == SEL_W'(i)) begin
        legal_c = 1'b1;
        word_c  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/operand_mux_stage.sv
// Registered, flow-controlled operand select stage with illegal-select tracking.
// Define OPERAND_MUX_SKID_EN for the registered-ready build with a one-word skid buffer.
module operand_mux_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned N_IN      = 3,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_legal;
  logic [WIDTH-1:0] last_word;
  logic             accept;
  logic             drain;
  pipe_state_t      state;

  operand_word_sel #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_word_sel (
    .in_data   (in_data),
    .sel       (in_sel),
    .last_word (last_word),
    .word_c    (sel_word),
    .legal_c   (sel_legal)
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Held word for illegal selects plus sticky flag and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_word <= '0;
      sel_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (accept && sel_legal) last_word <= sel_word;
      if (err_clr) begin
        sel_err <= 1'b0;
        err_cnt <= '0;
      end else if (accept && !sel_legal) begin
        sel_err <= 1'b1;
        if (err_cnt != {ERR_CNT_W{1'b1}}) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

`ifdef OPERAND_MUX_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic             rdy_q;

  assign in_ready = rdy_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
      rdy_q     <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data  <= sel_word;
            out_valid <= 1'b1;
            state     <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept && drain) begin
            out_data <= sel_word;
          end else if (accept) begin
            skid_data <= sel_word;
            rdy_q     <= 1'b0;
            state     <= ST_SKID;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drain) begin
            out_data <= skid_data;
            rdy_q    <= 1'b1;
            state    <= ST_MAIN;
          end
        end
        default: begin
          out_valid <= 1'b0;
          rdy_q     <= 1'b1;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);

  // Accept in MAIN implies the current word drains the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data  <= sel_word;
            out_valid <= 1'b1;
            state     <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept) begin
            out_data <= sel_word;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_EMPTY;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_operand_mux_stage.sv
// Bench for operand_mux_stage: vector table, scoreboard queue, hand-written corner sequences.
module tb_operand_mux_stage;

  logic          clk = 1'b0;
  logic          rst;
  logic [95:0]   in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;
  logic          err_clr;
  logic [7:0]    err_cnt;

  logic          in_ready2;
  logic [31:0]   out_data2;
  logic          out_valid2;
  logic          sel_err2;
  logic [1:0]    err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_mux_stage #(.WIDTH(32), .N_IN(3), .SEL_W(2), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  operand_mux_stage #(.WIDTH(32), .N_IN(3), .SEL_W(2), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .sel_err(sel_err2), .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected words queued on accept, compared on drain.
  logic [31:0] words [3];
  logic [31:0] sb_q [$];
  logic [31:0] m_last;
  logic        m_err;
  int          m_cnt;
  int          m_cnt2;

  always @(posedge clk) begin
    logic [31:0] w;
    if (rst) begin
      m_last = 32'h0;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
      sb_q.delete();
    end else begin
      chk("mon_sel_err", 32'(sel_err), 32'(m_err));
      chk("mon_err_cnt", 32'(err_cnt), 32'(m_cnt));
      chk("mon_err_cnt_sat", 32'(err_cnt2), 32'(m_cnt2));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) chk("sb_order", out_data, sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel < 2'd3) begin
          w      = words[in_sel];
          m_last = w;
        end else begin
          w = m_last;
          if (!err_clr) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
          end
        end
        sb_q.push_back(w);
      end
      if (err_clr) begin
        m_err  = 1'b0;
        m_cnt  = 0;
        m_cnt2 = 0;
      end
    end
  end

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    words[0] = 32'h11;
    words[1] = 32'h22;
    words[2] = 32'h33;
    in_data  = {32'h33, 32'h22, 32'h11};
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; out_ready = 1'b1; err_clr = 1'b0;

    vt[0] = '{2'd0, 32'h11};
    vt[1] = '{2'd1, 32'h22};
    vt[2] = '{2'd2, 32'h33};
    vt[3] = '{2'd3, 32'h33};
    vt[4] = '{2'd1, 32'h22};
    vt[5] = '{2'd3, 32'h22};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back vectors, each checked one cycle after its accept.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("vec_valid", 32'(out_valid), 32'd1);
        chk("vec_data", out_data, vt[i-1].exp);
      end
      in_valid = 1'b1;
      in_sel   = vt[i].sel;
    end
    @(negedge clk);
    chk("vec_valid_last", 32'(out_valid), 32'd1);
    chk("vec_data_last", out_data, vt[5].exp);
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("err_flag", 32'(sel_err), 32'd1);
    chk("err_cnt_two", 32'(err_cnt), 32'd2);

    // err_clr wins over a same-cycle illegal accept.
    err_clr = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    @(negedge clk);
    err_clr = 1'b0; in_valid = 1'b0;
    chk("clr_sel_err", 32'(sel_err), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_held_word", out_data, 32'h22);

    // Five illegal accepts: 8-bit counter reaches 5, 2-bit counter saturates at 3.
    in_valid = 1'b1; in_sel = 2'd3;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    chk("sat_err_cnt8", 32'(err_cnt), 32'd5);
    chk("sat_err_cnt2", 32'(err_cnt2), 32'd3);
    chk("sat_sel_err2", 32'(sel_err2), 32'd1);
    @(negedge clk);

    // Backpressure with two offered words.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    @(negedge clk);
    chk("bp_valid1", 32'(out_valid), 32'd1);
    chk("bp_data1", out_data, 32'h11);
`ifdef OPERAND_MUX_SKID_EN
    chk("bp_ready_main", 32'(in_ready), 32'd1);
`else
    chk("bp_ready_main", 32'(in_ready), 32'd0);
`endif
    in_sel = 2'd1;
    @(negedge clk);
    chk("bp_hold_data", out_data, 32'h11);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
`ifdef OPERAND_MUX_SKID_EN
    in_valid = 1'b0;
`endif
    out_ready = 1'b1;
`ifdef OPERAND_MUX_SKID_EN
    #1 chk("bp_ready_release", 32'(in_ready), 32'd0);
`else
    #1 chk("bp_ready_release", 32'(in_ready), 32'd1);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_valid2", 32'(out_valid), 32'd1);
    chk("bp_data2", out_data, 32'h22);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset while words are buffered.
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd3;
    @(negedge clk);
    in_sel = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_err_cnt", 32'(err_cnt), 32'd6);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", out_data, 32'h0);
    chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mrst_sel_err", 32'(sel_err), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    #1 chk("mrst_ready_after", 32'(in_ready), 32'd1);

    // Held word restarts from zero after reset.
    in_valid = 1'b1; in_sel = 2'd3;
    @(negedge clk);
    in_sel = 2'd2;
    chk("post_rst_held", out_data, 32'h0);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_legal", out_data, 32'h33);
    @(negedge clk);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
